// File: rtl/tbec_pkg.sv
// rtl/tbec_pkg.sv - shared constants for the TBEC code FIFO (register map, bit positions, widths)
package tbec_pkg;

   localparam int DATA_W   = 16;
   localparam int CODE_W   = 32;
   localparam int THRESH_W = 9;

   // Register index as decoded from PADDR[4:2]
   typedef enum logic [2:0] {
      OFF_DATA   = 3'd0,
      OFF_CODE   = 3'd1,
      OFF_STATUS = 3'd2,
      OFF_CTRL   = 3'd3,
      OFF_THRESH = 3'd4
   } reg_off_e;

   // STATUS bit positions
   localparam int ST_EMPTY   = 0;
   localparam int ST_FULL    = 1;
   localparam int ST_OVF     = 2;
   localparam int ST_UDF     = 3;
   localparam int ST_STAGE   = 4;
   localparam int ST_CNT_LSB = 8;

   // CTRL bit positions
   localparam int CTRL_FLUSH = 0;
   localparam int CTRL_CLR   = 1;

endpackage

// File: rtl/tbec_code_fifo.sv
// rtl/tbec_code_fifo.sv - DEPTH x 32 codeword FIFO with push/pop/flush and occupancy count
module tbec_code_fifo
   import tbec_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic                   flush_i,
   input  logic [CODE_W-1:0]      wdata_i,
   output logic [CODE_W-1:0]      rdata_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [CODE_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wptr_q, rptr_q;
   logic [AW:0]       count_q;

   // Storage array: contents survive reset and flush, only pointers move
   always_ff @(posedge clk_i) begin
      if (push_i && !rst_i && !flush_i) mem_q[wptr_q] <= wdata_i;
   end

   // Pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push_i) wptr_q <= wptr_q + 1'b1;
         if (pop_i)  rptr_q <= rptr_q + 1'b1;
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign rdata_o = mem_q[rptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/tbec_rsc_encoder.sv
// rtl/tbec_rsc_encoder.sv - TBEC-RSC encoder: systematic 16-bit data plus 16 recursive parity bits
module tbec_rsc_encoder
   import tbec_pkg::*;
(
   input  logic              en_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [CODE_W-1:0] code_o
);

   // Rate-1/2 recursive systematic code, memory 2, fed LSB first from a zero state.
   // feedback = d ^ s1 ^ s2, parity = feedback ^ s2; codeword = {parity, data}.
   function automatic logic [CODE_W-1:0] rsc_encode(input logic [DATA_W-1:0] d);
      logic              s1, s2, fb;
      logic [DATA_W-1:0] par;
      s1  = 1'b0;
      s2  = 1'b0;
      par = '0;
      for (int i = 0; i < DATA_W; i++) begin
         fb     = d[i] ^ s1 ^ s2;
         par[i] = fb ^ s2;
         s2     = s1;
         s1     = fb;
      end
      return {par, d};
   endfunction

   assign code_o = en_i ? rsc_encode(data_i) : '0;

endmodule

// File: rtl/apb_tbec_code_fifo.sv
// rtl/apb_tbec_code_fifo.sv - APB completer: stage -> TBEC-RSC encoder -> codeword FIFO (optional TBEC_IRQ_EN threshold irq)
module apb_tbec_code_fifo
   import tbec_pkg::*;
#(
   parameter int DEPTH      = 8,
   parameter int THRESH_RST = 4
) (
   input  logic        PCLK,
   input  logic        PRESET,
   input  logic [31:0] PADDR,
   input  logic [31:0] PWDATA,
   input  logic        PSEL,
   input  logic        PENABLE,
   input  logic        PWRITE,
   output logic [31:0] PRDATA,
   output logic        PREADY,
   output logic        PSLVERR
`ifdef TBEC_IRQ_EN
   ,
   output logic        irq
`endif
);

   localparam int CW = $clog2(DEPTH) + 1;

   if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0 ||
       THRESH_RST < 0 || THRESH_RST >= (1 << THRESH_W)) begin : g_bad_param
      $error("apb_tbec_code_fifo: illegal DEPTH or THRESH_RST");
   end

   logic [2:0]        sel;
   logic              acc, pready, done, err;
   logic              data_w, code_r, stat_r, ctrl_w, thr_acc, mapped;
   logic              fifo_empty, occ_full, push, pop, flush, clr;
   logic [CW-1:0]     count;
   logic [CODE_W-1:0] head, code;
   logic [31:0]       status;
   logic              stage_valid_q, stage_valid_d;
   logic [DATA_W-1:0] stage_data_q, stage_data_d;
   logic              ovf_q, ovf_d, udf_q, udf_d;
   logic [THRESH_W-1:0] thresh_rd;
   logic              unused_bits;

   assign sel         = PADDR[4:2];
   assign unused_bits = ^{PADDR[31:5], PADDR[1:0], PWDATA[31:16]};

`ifdef TBEC_IRQ_EN
   logic [THRESH_W-1:0] thresh_q, thresh_d;
   logic                irq_q, irq_d;
   assign thr_acc   = (sel == OFF_THRESH);
   assign thresh_rd = thresh_q;
   assign irq       = irq_q;
`else
   assign thr_acc   = 1'b0;
   assign thresh_rd = '0;
`endif

   // Address/direction decode and access qualification; reset aborts any transfer
   always_comb begin
      data_w     = PWRITE  && (sel == OFF_DATA);
      code_r     = !PWRITE && (sel == OFF_CODE);
      stat_r     = !PWRITE && (sel == OFF_STATUS);
      ctrl_w     = PWRITE  && (sel == OFF_CTRL);
      mapped     = data_w || code_r || stat_r || ctrl_w || thr_acc;
      fifo_empty = (count == '0);
      occ_full   = (count == CW'(DEPTH)) || (stage_valid_q && count == CW'(DEPTH - 1));
      acc        = PSEL && PENABLE && !PRESET;
      // A pop racing the stage push waits one cycle for the codeword to land
      pready     = !(acc && code_r && fifo_empty && stage_valid_q);
      done       = acc && pready;
      err        = !mapped || (data_w && occ_full) || (code_r && fifo_empty && !stage_valid_q);
   end

   assign PREADY  = pready;
   assign PSLVERR = done && err;

   // Read data mux: zero except during a non-errored read access phase
   always_comb begin
      status                        = '0;
      status[ST_EMPTY]              = fifo_empty;
      status[ST_FULL]               = (count == CW'(DEPTH));
      status[ST_OVF]                = ovf_q;
      status[ST_UDF]                = udf_q;
      status[ST_STAGE]              = stage_valid_q;
      status[ST_CNT_LSB +: THRESH_W] = THRESH_W'(count);
      PRDATA = '0;
      if (acc && !PWRITE && !err) begin
         if (code_r)       PRDATA = head;
         else if (stat_r)  PRDATA = status;
         else if (thr_acc) PRDATA = 32'(thresh_rd);
      end
   end

   // Next-state for stage, sticky flags and (optionally) threshold/irq
   always_comb begin
      flush         = done && ctrl_w && PWDATA[CTRL_FLUSH];
      clr           = done && ctrl_w && PWDATA[CTRL_CLR];
      push          = stage_valid_q && !flush;
      pop           = done && code_r && !err;
      stage_valid_d = done && data_w && !err && !flush;
      stage_data_d  = (done && data_w && !err) ? PWDATA[DATA_W-1:0] : stage_data_q;
      ovf_d         = (done && data_w && occ_full) || (ovf_q && !clr);
      udf_d         = (done && code_r && fifo_empty && !stage_valid_q) || (udf_q && !clr);
`ifdef TBEC_IRQ_EN
      thresh_d      = (done && thr_acc && PWRITE) ? PWDATA[THRESH_W-1:0] : thresh_q;
      irq_d         = (thresh_q != '0) && (THRESH_W'(count) >= thresh_q);
`endif
   end

   // Register update with synchronous reset; stage data itself is not cleared
   always_ff @(posedge PCLK) begin
      stage_data_q <= stage_data_d;
      if (PRESET) begin
         stage_valid_q <= 1'b0;
         ovf_q         <= 1'b0;
         udf_q         <= 1'b0;
`ifdef TBEC_IRQ_EN
         thresh_q      <= THRESH_W'(THRESH_RST);
         irq_q         <= 1'b0;
`endif
      end else begin
         stage_valid_q <= stage_valid_d;
         ovf_q         <= ovf_d;
         udf_q         <= udf_d;
`ifdef TBEC_IRQ_EN
         thresh_q      <= thresh_d;
         irq_q         <= irq_d;
`endif
      end
   end

   tbec_rsc_encoder u_enc (
      .en_i   (1'b1),
      .data_i (stage_data_q),
      .code_o (code)
   );

   tbec_code_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i   (PCLK),
      .rst_i   (PRESET),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (flush),
      .wdata_i (code),
      .rdata_o (head),
      .count_o (count)
   );

endmodule

// File: tb/tb_apb_tbec_code_fifo.sv
// tb/tb_apb_tbec_code_fifo.sv - scoreboard bench for apb_tbec_code_fifo
`timescale 1ns/1ps
module tb_apb_tbec_code_fifo;

   logic        PCLK = 1'b0;
   logic        PRESET = 1'b1;
   logic [31:0] PADDR = '0, PWDATA = '0;
   logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
   logic [31:0] PRDATA;
   logic        PREADY, PSLVERR;
`ifdef TBEC_IRQ_EN
   logic        irq;
`endif

   int checks = 0;
   int failures = 0;
   logic [32:0] exp_q [$];

   localparam logic [31:0] A_DATA = 32'h00, A_CODE = 32'h04, A_STAT = 32'h08,
                           A_CTRL = 32'h0C, A_THR = 32'h10, A_BAD = 32'h14;

   always #5 PCLK = ~PCLK;

   apb_tbec_code_fifo dut (
      .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PWDATA(PWDATA),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
`ifdef TBEC_IRQ_EN
      , .irq(irq)
`endif
   );

   function automatic logic [31:0] enc_model(input logic [15:0] d);
      logic [1:0]  st;
      logic [15:0] p;
      logic        f;
      st = 2'b00;
      p  = '0;
      for (int i = 0; i < 16; i++) begin
         f    = d[i] ^ st[0] ^ st[1];
         p[i] = f ^ st[1];
         st   = {st[0], f};
      end
      return {p, d};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: every completed transfer is compared against the next scoreboard entry
   always @(negedge PCLK) begin
      if (!PRESET && PSEL && PENABLE && PREADY) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_completion: addr 0x%08h with empty scoreboard", PADDR);
         end else begin
            logic [32:0] e;
            e = exp_q.pop_front();
            check("prdata", PRDATA, e[32:1]);
            check("pslverr", 32'(PSLVERR), 32'(e[0]));
         end
      end
   end

   // One APB transfer; setup=0 jumps straight into an access phase (back-to-back)
   task automatic apb(input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic [31:0] er, input logic ee, input bit setup, output int waits);
      exp_q.push_back({er, ee});
      PADDR = a; PWRITE = w; PWDATA = d; PSEL = 1'b1;
      if (setup) begin
         PENABLE = 1'b0;
         @(posedge PCLK); #1;
      end
      PENABLE = 1'b1;
      waits = 0;
      @(negedge PCLK);
      while (!PREADY && waits < 20) begin
         waits++;
         @(negedge PCLK);
      end
      if (!PREADY) begin
         checks++;
         failures++;
         $display("FAIL pready_timeout: addr 0x%08h still waiting", a);
      end
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic ee, input bit setup);
      int w;
      apb(a, 1'b1, d, 32'h0, ee, setup, w);
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] er, input logic ee, input bit setup);
      int w;
      apb(a, 1'b0, 32'h0, er, ee, setup, w);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [15:0] wv [9];
      int w;
      wv = '{16'h0001, 16'h1234, 16'hFFFF, 16'h8000, 16'h00FF, 16'hBEEF, 16'h5A5A, 16'h0F0F, 16'hC001};

      // Reset: outputs stay idle even with a request present
      PSEL = 1'b1; PENABLE = 1'b1; PADDR = A_STAT;
      repeat (3) @(posedge PCLK);
      @(negedge PCLK);
      check("rst_pready", 32'(PREADY), 32'h1);
      check("rst_pslverr", 32'(PSLVERR), 32'h0);
      check("rst_prdata", PRDATA, 32'h0);
`ifdef TBEC_IRQ_EN
      check("rst_irq", 32'(irq), 32'h0);
`endif
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0; PRESET = 1'b0;
      @(posedge PCLK); #1;

      rd(A_STAT, 32'h00000001, 1'b0, 1'b1);
      @(negedge PCLK);
      check("idle_prdata", PRDATA, 32'h0);
      @(posedge PCLK); #1;

      // Write then immediate pop: one wait state, hand-computed codeword
      wr(A_DATA, 32'h0000A5A5, 1'b0, 1'b1);
      apb(A_CODE, 1'b0, 32'h0, 32'hBD0BA5A5, 1'b0, 1'b0, w);
      check("wait_states", 32'(w), 32'd1);
      rd(A_STAT, 32'h00000001, 1'b0, 1'b1);

      // Overflow at DEPTH=8, then drain in order
      for (int i = 0; i < 9; i++) wr(A_DATA, {16'hDEAD, wv[i]}, (i == 8), 1'b1);
      repeat (2) @(posedge PCLK); #1;
      rd(A_STAT, 32'h00000806, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) rd(A_CODE, enc_model(wv[i]), 1'b0, 1'b1);
      rd(A_STAT, 32'h00000005, 1'b0, 1'b1);
      wr(A_CTRL, 32'h2, 1'b0, 1'b1);
      rd(A_STAT, 32'h00000001, 1'b0, 1'b1);

      // Underflow, then sticky clear
      rd(A_CODE, 32'h0, 1'b1, 1'b1);
      rd(A_STAT, 32'h00000009, 1'b0, 1'b1);
      wr(A_CTRL, 32'h2, 1'b0, 1'b1);
      rd(A_STAT, 32'h00000001, 1'b0, 1'b1);

      // Flush colliding with the third word's stage push
      wr(A_DATA, 32'h1111, 1'b0, 1'b1);
      wr(A_DATA, 32'h2222, 1'b0, 1'b1);
      wr(A_DATA, 32'h3333, 1'b0, 1'b1);
      wr(A_CTRL, 32'h1, 1'b0, 1'b0);
      rd(A_STAT, 32'h00000001, 1'b0, 1'b1);
      rd(A_CODE, 32'h0, 1'b1, 1'b1);
      wr(A_CTRL, 32'h2, 1'b0, 1'b1);

      // Unmapped offsets and wrong directions
      rd(A_BAD, 32'h0, 1'b1, 1'b1);
      wr(A_CODE, 32'h1234, 1'b1, 1'b1);
      rd(A_DATA, 32'h0, 1'b1, 1'b1);
      wr(A_STAT, 32'hFFFF, 1'b1, 1'b1);
      rd(A_STAT, 32'h00000001, 1'b0, 1'b1);

      // Pop on the same edge as a stage push keeps count
      wr(A_DATA, 32'h0001, 1'b0, 1'b1);
      wr(A_DATA, 32'h0002, 1'b0, 1'b1);
      wr(A_DATA, 32'h0003, 1'b0, 1'b1);
      rd(A_CODE, enc_model(16'h0001), 1'b0, 1'b0);
      rd(A_STAT, 32'h00000200, 1'b0, 1'b1);
      rd(A_CODE, enc_model(16'h0002), 1'b0, 1'b1);
      rd(A_CODE, enc_model(16'h0003), 1'b0, 1'b1);
      rd(A_STAT, 32'h00000001, 1'b0, 1'b1);

`ifdef TBEC_IRQ_EN
      rd(A_THR, 32'h4, 1'b0, 1'b1);
      wr(A_THR, 32'h2, 1'b0, 1'b1);
      rd(A_THR, 32'h2, 1'b0, 1'b1);
      wr(A_DATA, 32'h00AA, 1'b0, 1'b1);
      wr(A_DATA, 32'h00BB, 1'b0, 1'b1);
      @(negedge PCLK);
      check("irq_before_push", 32'(irq), 32'h0);
      @(negedge PCLK);
      check("irq_count2_same_cycle", 32'(irq), 32'h0);
      @(negedge PCLK);
      check("irq_rise", 32'(irq), 32'h1);
      @(posedge PCLK); #1;
      rd(A_CODE, enc_model(16'h00AA), 1'b0, 1'b1);
      @(negedge PCLK);
      check("irq_hold_after_pop", 32'(irq), 32'h1);
      @(negedge PCLK);
      check("irq_fall", 32'(irq), 32'h0);
      @(posedge PCLK); #1;
`else
      rd(A_THR, 32'h0, 1'b1, 1'b1);
      wr(A_THR, 32'h2, 1'b1, 1'b1);
`endif
      rd(A_BAD, 32'h0, 1'b1, 1'b1);

      for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge PCLK);
      check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
